// File: rtl/bcd_stopwatch_if.sv
// Button inputs and display/status outputs of the BCD stopwatch.
// The stopwatch is the slave; whatever drives the buttons is the master.
interface bcd_stopwatch_if #(
  parameter int DIGITS = 4
);
  logic                  btn_start;
  logic                  btn_lap;
  logic                  btn_clear;
  logic [4*DIGITS-1:0]   count;
  logic [4*DIGITS-1:0]   disp;
  logic [1:0]            state;
  logic                  tick;
  logic                  overflow;

  modport master (
    output btn_start, btn_lap, btn_clear,
    input  count, disp, state, tick, overflow
  );

  modport slave (
    input  btn_start, btn_lap, btn_clear,
    output count, disp, state, tick, overflow
  );
endinterface

// File: rtl/bcd_stopwatch.sv
// Multi-digit BCD stopwatch: button synchronisers/edge detectors, tick
// prescaler, cascaded BCD counter with lap freeze, and a 4-state control FSM.
module bcd_stopwatch #(
  parameter int DIGITS  = 4,
  parameter int CLK_DIV = 100,
  parameter int WRAP    = 1
) (
  input  logic             clk,
  input  logic             nrst,
  bcd_stopwatch_if.slave   sw
);
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    RUNNING = 2'b01,
    STOPPED = 2'b10,
    LAP     = 2'b11
  } state_t;

  localparam int PW = $clog2(CLK_DIV);
  localparam int CW = 4 * DIGITS;

  // Button vectors are ordered {clear, lap, start}.
  logic [2:0] btn_raw;
  logic [2:0] sync1_q, sync2_q, prev_q;
  logic [2:0] ev;
  logic       ev_start, ev_lap, ev_clear;

  state_t          state_q;
  logic [PW-1:0]   presc_q;
  logic [CW-1:0]   count_q;
  logic [CW-1:0]   lap_q;
  logic            ovf_q;

  logic            running;
  logic            tick;
  logic            do_clear;
  logic            lap_go;
  logic            all_nine;
  logic [CW-1:0]   count_inc;

  assign btn_raw  = {sw.btn_clear, sw.btn_lap, sw.btn_start};
  assign ev       = sync2_q & ~prev_q;
  assign ev_start = ev[0];
  assign ev_lap   = ev[1];
  assign ev_clear = ev[2];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= btn_raw;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign running  = (state_q == RUNNING) || (state_q == LAP);
  assign tick     = running && (presc_q == PW'(CLK_DIV - 1));
  assign do_clear = (state_q == STOPPED) && ev_clear;
  // Lap capture only when lap is the winning event out of RUNNING.
  assign lap_go   = (state_q == RUNNING) && !ev_start && ev_lap;

  // Ripple-carry BCD increment; all_nine ends up as the carry out of the top digit.
  always_comb begin
    count_inc = count_q;
    all_nine  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (all_nine) begin
        count_inc[4*i +: 4] = (count_q[4*i +: 4] == 4'd9) ? 4'd0 : count_q[4*i +: 4] + 4'd1;
      end
      all_nine = all_nine && (count_q[4*i +: 4] == 4'd9);
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE:    if (ev_start) state_q <= RUNNING;
        RUNNING: if (ev_start) state_q <= STOPPED;
                 else if (ev_lap) state_q <= LAP;
        LAP:     if (ev_start) state_q <= STOPPED;
                 else if (ev_lap) state_q <= RUNNING;
        STOPPED: if (ev_clear) state_q <= IDLE;
                 else if (ev_start) state_q <= RUNNING;
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      presc_q <= '0;
      count_q <= '0;
      lap_q   <= '0;
      ovf_q   <= 1'b0;
    end else if (do_clear) begin
      presc_q <= '0;
      count_q <= '0;
      lap_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // Prescaler holds outside RUNNING/LAP so a resumed sub-tick fraction survives.
      if (running) presc_q <= tick ? '0 : presc_q + PW'(1);
      if (lap_go)  lap_q   <= count_q;
      if (tick) begin
        if (all_nine) ovf_q <= 1'b1;
        if (!all_nine || (WRAP != 0)) count_q <= count_inc;
      end
    end
  end

  assign sw.count    = count_q;
  assign sw.disp     = (state_q == LAP) ? lap_q : count_q;
  assign sw.state    = state_q;
  assign sw.tick     = tick;
  assign sw.overflow = ovf_q;
endmodule

// File: tb/tb_bcd_stopwatch.sv
// Bench for bcd_stopwatch: a wrapping and a saturating instance share the
// same buttons and are compared every cycle against a decimal reference model.
module tb_bcd_stopwatch;
  localparam int D    = 2;
  localparam int CD   = 4;
  localparam int W    = 4 * D;
  localparam int MAXV = 99;

  logic clk;
  logic nrst;

  bcd_stopwatch_if #(.DIGITS(D)) if_w ();
  bcd_stopwatch_if #(.DIGITS(D)) if_s ();

  bcd_stopwatch #(.DIGITS(D), .CLK_DIV(CD), .WRAP(1)) dut_w (
    .clk  (clk),
    .nrst (nrst),
    .sw   (if_w)
  );

  bcd_stopwatch #(.DIGITS(D), .CLK_DIV(CD), .WRAP(0)) dut_s (
    .clk  (clk),
    .nrst (nrst),
    .sw   (if_s)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // States: 0 idle, 1 running, 2 stopped, 3 lap. Counts kept as plain integers.
  int m_state;
  int m_presc;
  int m_cnt[2];   // [0] wrapping, [1] saturating
  int m_lap[2];
  int m_ovf[2];
  int m_seen[3][3]; // per button: what the bench saw at the last three edges, newest first
  int m_ticked;

  function automatic logic [W-1:0] to_bcd(input int v);
    logic [W-1:0] r;
    int p;
    r = '0;
    p = 1;
    for (int i = 0; i < D; i++) begin
      r[4*i +: 4] = 4'((v / p) % 10);
      p = p * 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state = 0; m_presc = 0; m_ticked = 0;
    for (int k = 0; k < 2; k++) begin
      m_cnt[k] = 0; m_lap[k] = 0; m_ovf[k] = 0;
    end
    for (int b = 0; b < 3; b++)
      for (int a = 0; a < 3; a++) m_seen[b][a] = 0;
  endtask

  task automatic model_step();
    int  ev[3];
    int  btn[3];
    int  act;
    if (!nrst) begin
      model_reset();
      return;
    end
    btn[0] = int'(if_w.btn_start);
    btn[1] = int'(if_w.btn_lap);
    btn[2] = int'(if_w.btn_clear);
    // A press registers once: seen high two edges ago, low three edges ago.
    for (int b = 0; b < 3; b++) begin
      ev[b] = (m_seen[b][1] == 1 && m_seen[b][2] == 0) ? 1 : 0;
      m_seen[b][2] = m_seen[b][1];
      m_seen[b][1] = m_seen[b][0];
      m_seen[b][0] = btn[b];
    end
    act = (m_state == 1 || m_state == 3) ? 1 : 0;
    m_ticked = (act == 1 && m_presc == CD - 1) ? 1 : 0;
    if (m_state == 1 && ev[0] == 0 && ev[1] == 1) begin
      m_lap[0] = m_cnt[0];
      m_lap[1] = m_cnt[1];
    end
    if (act == 1) m_presc = (m_ticked == 1) ? 0 : m_presc + 1;
    if (m_ticked == 1) begin
      for (int k = 0; k < 2; k++) begin
        if (m_cnt[k] == MAXV) begin
          m_ovf[k] = 1;
          if (k == 0) m_cnt[k] = 0;
        end else begin
          m_cnt[k] = m_cnt[k] + 1;
        end
      end
      exp_q.push_back(to_bcd(m_cnt[0]));
    end
    case (m_state)
      0: if (ev[0] == 1) m_state = 1;
      1: if (ev[0] == 1) m_state = 2; else if (ev[1] == 1) m_state = 3;
      3: if (ev[0] == 1) m_state = 2; else if (ev[1] == 1) m_state = 1;
      default: begin
        if (ev[2] == 1) begin
          m_state = 0; m_presc = 0;
          for (int k = 0; k < 2; k++) begin
            m_cnt[k] = 0; m_lap[k] = 0; m_ovf[k] = 0;
          end
        end else if (ev[0] == 1) begin
          m_state = 1;
        end
      end
    endcase
  endtask

  task automatic check_all();
    logic exp_tick;
    exp_tick = ((m_state == 1 || m_state == 3) && m_presc == CD - 1);
    check("state_w", 32'(if_w.state), 32'(m_state));
    check("state_s", 32'(if_s.state), 32'(m_state));
    check("count_w", 32'(if_w.count), 32'(to_bcd(m_cnt[0])));
    check("count_s", 32'(if_s.count), 32'(to_bcd(m_cnt[1])));
    check("disp_w",  32'(if_w.disp),  32'(to_bcd(m_state == 3 ? m_lap[0] : m_cnt[0])));
    check("disp_s",  32'(if_s.disp),  32'(to_bcd(m_state == 3 ? m_lap[1] : m_cnt[1])));
    check("tick_w",  32'(if_w.tick),  32'(exp_tick));
    check("tick_s",  32'(if_s.tick),  32'(exp_tick));
    check("ovf_w",   32'(if_w.overflow), 32'(m_ovf[0]));
    check("ovf_s",   32'(if_s.overflow), 32'(m_ovf[1]));
    while (exp_q.size() > 0) check("tick_count", 32'(if_w.count), 32'(exp_q.pop_front()));
  endtask

  // ---------------- driver tasks ----------------
  task automatic set_btn(input int mask);
    if_w.btn_start = mask[0]; if_w.btn_lap = mask[1]; if_w.btn_clear = mask[2];
    if_s.btn_start = mask[0]; if_s.btn_lap = mask[1]; if_s.btn_clear = mask[2];
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  // mask bits: 0 start, 1 lap, 2 clear
  task automatic press(input int mask, input int hold);
    set_btn(mask);
    run(hold);
    set_btn(0);
    run(2);
  endtask

  task automatic run_until_cnt(input string tag, input int target);
    int budget;
    budget = 2000;
    while (m_cnt[0] != target && budget > 0) begin
      cycle();
      budget--;
    end
    if (budget == 0) check(tag, 32'(m_cnt[0]), 32'(target));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int trans;
    logic [1:0] prev_st;
    nrst = 1'b0;
    set_btn(0);
    model_reset();
    #1;
    check("rst_state", 32'(if_w.state), 32'h0);
    check("rst_count", 32'(if_w.count), 32'h0);
    run(3);
    nrst = 1'b1;
    run(2);

    // start from idle, then carry 09 -> 10 after 10 ticks
    press(1, 3);
    check("start_run", 32'(if_w.state), 32'h1);
    run(38);
    check("carry_10", 32'(if_w.count), 32'h10);

    // wrap vs saturate at 99
    run_until_cnt("to_99", MAXV);
    run_until_cnt("to_wrap", 0);
    check("wrap_cnt", 32'(if_w.count), 32'h00);
    check("wrap_ovf", 32'(if_w.overflow), 32'h1);
    check("sat_cnt",  32'(if_s.count), 32'h99);
    check("sat_ovf",  32'(if_s.overflow), 32'h1);

    // lap freeze at 23
    run_until_cnt("to_23", 23);
    press(2, 3);
    check("lap_state", 32'(if_w.state), 32'h3);
    check("lap_disp", 32'(if_w.disp), 32'h23);
    run_until_cnt("to_27", 27);
    check("lap_frozen", 32'(if_w.disp), 32'h23);
    press(2, 3);
    check("lap_exit", 32'(if_w.state), 32'h1);

    // stop, hold 20 cycles, resume; clear ignored while running
    run(6);
    press(1, 3);
    check("stop_state", 32'(if_w.state), 32'h2);
    run(20);
    press(1, 3);
    run(9);
    press(4, 3);
    check("clr_ign", 32'(if_w.state), 32'h1);

    // clear+start together in STOPPED; start+lap together in RUNNING
    press(1, 3);
    press(5, 3);
    check("clr_state", 32'(if_w.state), 32'h0);
    check("clr_count", 32'(if_w.count), 32'h0);
    check("clr_ovf",   32'(if_w.overflow), 32'h0);
    press(1, 3);
    run(7);
    press(3, 3);
    check("st_lap_pri", 32'(if_w.state), 32'h2);

    // async reset while in LAP at 45
    press(4, 3);
    press(1, 3);
    press(2, 3);
    run_until_cnt("to_45", 45);
    nrst = 1'b0;
    #1;
    model_reset();
    check("arst_count", 32'(if_w.count), 32'h0);
    check("arst_disp",  32'(if_w.disp), 32'h0);
    check("arst_state", 32'(if_w.state), 32'h0);
    cycle();
    nrst = 1'b1;
    run(3);

    // held button gives a single event
    trans = 0;
    prev_st = if_w.state;
    set_btn(1);
    repeat (50) begin
      cycle();
      if (if_w.state !== prev_st) trans++;
      prev_st = if_w.state;
    end
    set_btn(0);
    run(2);
    check("hold_one", 32'(trans), 32'h1);

    // randomized button traffic
    for (int i = 0; i < 200; i++) begin
      set_btn(int'($urandom_range(0, 7)));
      run(int'($urandom_range(3, 6)));
      set_btn(0);
      run(int'($urandom_range(1, 40)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
